// File: rtl/fnd_scan_sequencer_if.sv
//==============================================================================
// Module   : fnd_scan_sequencer_if
// Brief    : Value-load and FND pin bundle between datapath and scan sequencer.
// Revision : 1.0
//==============================================================================
`default_nettype none

interface fnd_scan_sequencer_if #(
    parameter int VALUE_W = 14
);
    logic [VALUE_W-1:0] i_value;
    logic               i_load;
    logic               o_busy;
    logic [3:0]         fnd_digit;
    logic [7:0]         fnd_data;

    modport master (
        output i_value,
        output i_load,
        input  o_busy,
        input  fnd_digit,
        input  fnd_data
    );

    modport slave (
        input  i_value,
        input  i_load,
        output o_busy,
        output fnd_digit,
        output fnd_data
    );
endinterface

`default_nettype wire

// File: rtl/fnd_scan_sequencer.sv
//==============================================================================
// Module   : fnd_scan_sequencer
// Brief    : 4-digit FND scanner with frame-aligned updates and iterative
//            binary->BCD conversion. Optional macro FND_LZS_EN enables
//            leading-zero suppression.
// Revision : 1.0
//==============================================================================
`default_nettype none

module fnd_scan_sequencer #(
    parameter int CLK_HZ    = 100_000_000,
    parameter int SCAN_HZ   = 1_000,
    parameter int BLANK_CYC = 1_000,
    parameter int VALUE_W   = 14
) (
    input  wire logic             clk,
    input  wire logic             reset,
    fnd_scan_sequencer_if.slave   bus
);

    localparam int c_digit_cyc = CLK_HZ / SCAN_HZ;
    localparam int c_show_cyc  = c_digit_cyc - BLANK_CYC;
    localparam int c_tmr_w_dig = $clog2(c_digit_cyc);
    localparam int c_tmr_w_cnv = $clog2(VALUE_W);
    localparam int c_tmr_w     = (c_tmr_w_dig > c_tmr_w_cnv) ? c_tmr_w_dig : c_tmr_w_cnv;
    localparam int c_max_val   = 9999;

    // The timer restarts at zero on each state change and counts down with
    // wrap-around, so a state of N cycles ends when it reaches -(N-1).
    localparam logic [c_tmr_w-1:0] c_show_end  = c_tmr_w'((1 << c_tmr_w) - (c_show_cyc - 1));
    localparam logic [c_tmr_w-1:0] c_blank_end = c_tmr_w'((1 << c_tmr_w) - (BLANK_CYC - 1));
    localparam logic [c_tmr_w-1:0] c_conv_end  = c_tmr_w'((1 << c_tmr_w) - (VALUE_W - 1));

    typedef enum logic [1:0] {
        S_SHOW  = 2'd0,
        S_BLANK = 2'd1,
        S_CONV  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [c_tmr_w-1:0]   r_timer;
    logic [1:0]           r_digit_sel;
    logic [1:0]           w_digit_sel_next;
    logic [VALUE_W-1:0]   r_shadow;
    logic                 r_pending;
    logic [VALUE_W-1:0]   r_bin;
    logic [15:0]          r_bcd;
    logic [15:0]          r_disp;
    logic                 r_busy;
    logic [3:0]           r_fnd_digit;
    logic [7:0]           r_fnd_data;

    logic                 w_start_conv;
    logic                 w_conv_last;
    logic [VALUE_W-1:0]   w_src;
    logic [VALUE_W-1:0]   w_clamped;
    logic [15:0]          w_adj;
    logic [15:0]          w_bcd_step;
    logic                 w_unused_bcd_msb;
    logic [3:0]           w_nibble;
    logic [3:0]           w_lz;
    logic                 w_busy;
    logic [3:0]           w_fnd_digit;
    logic [7:0]           w_fnd_data;

    function automatic logic [15:0] f_add3(input logic [15:0] bcd);
        logic [15:0] res;
        res = bcd;
        for (int i = 0; i < 4; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5) begin
                res[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
            end
        end
        return res;
    endfunction

    function automatic logic [7:0] f_seg(input logic [3:0] nib);
        logic [7:0] seg;
        case (nib)
            4'd0:    seg = 8'hC0;
            4'd1:    seg = 8'hF9;
            4'd2:    seg = 8'hA4;
            4'd3:    seg = 8'hB0;
            4'd4:    seg = 8'h99;
            4'd5:    seg = 8'h92;
            4'd6:    seg = 8'h82;
            4'd7:    seg = 8'hF8;
            4'd8:    seg = 8'h80;
            4'd9:    seg = 8'h90;
            default: seg = 8'hFF;
        endcase
        return seg;
    endfunction

    // A load in the boundary cycle is converted directly, bypassing the shadow.
    assign w_src     = bus.i_load ? bus.i_value : r_shadow;
    assign w_clamped = (32'(w_src) > 32'(c_max_val)) ? VALUE_W'(c_max_val) : w_src;

    assign w_adj            = f_add3(r_bcd);
    assign w_bcd_step       = {w_adj[14:0], r_bin[VALUE_W-1]};
    assign w_unused_bcd_msb = w_adj[15];

    assign w_nibble = r_disp[r_digit_sel*4 +: 4];

    always_comb begin
        w_lz = 4'b0000;
`ifdef FND_LZS_EN
        w_lz[3] = (r_disp[15:12] == 4'd0);
        w_lz[2] = w_lz[3] && (r_disp[11:8] == 4'd0);
        w_lz[1] = w_lz[2] && (r_disp[7:4] == 4'd0);
`endif
    end

    // Next-state and output decode
    always_comb begin
        w_next_state     = r_state;
        w_digit_sel_next = r_digit_sel;
        w_start_conv     = 1'b0;
        w_conv_last      = 1'b0;
        w_busy           = 1'b0;
        w_fnd_digit      = 4'b1111;
        w_fnd_data       = 8'hFF;

        case (r_state)
            S_SHOW: begin
                w_fnd_digit = ~(4'b0001 << r_digit_sel);
                w_fnd_data  = w_lz[r_digit_sel] ? 8'hFF : f_seg(w_nibble);
                if (r_timer == c_show_end) begin
                    w_next_state = S_BLANK;
                end
            end
            S_BLANK: begin
                if (r_timer == c_blank_end) begin
                    if (r_digit_sel != 2'd3) begin
                        w_digit_sel_next = r_digit_sel + 2'd1;
                        w_next_state     = S_SHOW;
                    end else if (r_pending || bus.i_load) begin
                        w_start_conv = 1'b1;
                        w_next_state = S_CONV;
                    end else begin
                        w_digit_sel_next = 2'd0;
                        w_next_state     = S_SHOW;
                    end
                end
            end
            S_CONV: begin
                w_busy = 1'b1;
                if (r_timer == c_conv_end) begin
                    w_conv_last      = 1'b1;
                    w_digit_sel_next = 2'd0;
                    w_next_state     = S_SHOW;
                end
            end
            default: begin
                w_next_state     = S_SHOW;
                w_digit_sel_next = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_SHOW;
            r_timer     <= '0;
            r_digit_sel <= 2'd0;
            r_shadow    <= '0;
            r_pending   <= 1'b0;
            r_bin       <= '0;
            r_bcd       <= '0;
            r_disp      <= '0;
            r_busy      <= 1'b0;
            r_fnd_digit <= 4'b1111;
            r_fnd_data  <= 8'hFF;
        end else begin
            r_state     <= w_next_state;
            r_timer     <= (w_next_state != r_state) ? '0 : r_timer - 1'b1;
            r_digit_sel <= w_digit_sel_next;

            if (bus.i_load) begin
                r_shadow <= bus.i_value;
            end

            if (bus.i_load) begin
                r_pending <= 1'b1;
            end else if (w_start_conv) begin
                r_pending <= 1'b0;
            end

            if (w_start_conv) begin
                r_bin <= w_clamped;
                r_bcd <= '0;
            end else if (r_state == S_CONV) begin
                r_bin <= r_bin << 1;
                r_bcd <= w_bcd_step;
            end

            if (w_conv_last) begin
                r_disp <= w_bcd_step;
            end

            r_busy      <= w_busy;
            r_fnd_digit <= w_fnd_digit;
            r_fnd_data  <= w_fnd_data;
        end
    end

    assign bus.o_busy    = r_busy;
    assign bus.fnd_digit = r_fnd_digit;
    assign bus.fnd_data  = r_fnd_data;

endmodule

`default_nettype wire

// File: tb/tb_fnd_scan_sequencer.sv
//==============================================================================
// Module   : tb_fnd_scan_sequencer
// Brief    : Scoreboard bench for fnd_scan_sequencer: expected display segments
//            queued by stimulus, popped by a segment monitor.
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_fnd_scan_sequencer;

`ifdef FND_LZS_EN
    localparam logic [7:0] LZ = 8'hFF;
`else
    localparam logic [7:0] LZ = 8'hC0;
`endif

    typedef struct {
        logic       busy;
        logic [3:0] dig;
        logic [7:0] dat;
        int         len;
    } seg_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   seg_idx;

    seg_t        exp_q[$];
    logic        armed;
    logic [12:0] cur_key;
    int          cur_len;

    fnd_scan_sequencer_if #(.VALUE_W(14)) bus();

    fnd_scan_sequencer #(
        .CLK_HZ    (1000),
        .SCAN_HZ   (100),
        .BLANK_CYC (2),
        .VALUE_W   (14)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push_seg(input logic busy, input logic [3:0] dig, input logic [7:0] dat, input int len);
        seg_t s;
        s.busy = busy; s.dig = dig; s.dat = dat; s.len = len;
        exp_q.push_back(s);
    endtask

    task automatic push_frame(input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2, input logic [7:0] d3);
        logic [7:0] d [4];
        d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
        for (int i = 0; i < 4; i++) begin
            push_seg(1'b0, ~(4'b0001 << i), d[i], 8);
            push_seg(1'b0, 4'b1111, 8'hFF, 2);
        end
    endtask

    task automatic push_busy();
        push_seg(1'b1, 4'b1111, 8'hFF, 14);
    endtask

    task automatic close_seg();
        seg_t e;
        checks++;
        seg_idx++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL seg%0d unexpected: busy=%0b dig=%b dat=%h len=%0d, queue empty",
                     seg_idx, cur_key[12], cur_key[11:8], cur_key[7:0], cur_len);
        end else begin
            e = exp_q.pop_front();
            if (cur_key != {e.busy, e.dig, e.dat} || cur_len != e.len) begin
                errors++;
                $display("FAIL seg%0d actual busy=%0b dig=%b dat=%h len=%0d required busy=%0b dig=%b dat=%h len=%0d",
                         seg_idx, cur_key[12], cur_key[11:8], cur_key[7:0], cur_len,
                         e.busy, e.dig, e.dat, e.len);
            end
        end
    endtask

    task automatic chk_reset_outs(input string name);
        checks++;
        if ({bus.o_busy, bus.fnd_digit, bus.fnd_data} != {1'b0, 4'b1111, 8'hFF}) begin
            errors++;
            $display("FAIL %s actual busy=%0b dig=%b dat=%h required busy=0 dig=1111 dat=ff",
                     name, bus.o_busy, bus.fnd_digit, bus.fnd_data);
        end
    endtask

    task automatic load(input logic [13:0] v);
        bus.i_value = v;
        bus.i_load  = 1'b1;
        @(posedge clk);
        #1 bus.i_load = 1'b0;
    endtask

    task automatic wait_dig(input logic [3:0] d);
        bit hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge clk);
            if (bus.fnd_digit == d) hit = 1'b1;
        end
        if (!hit) begin
            checks++; errors++;
            $display("FAIL wait_dig timeout actual dig=%b required dig=%b", bus.fnd_digit, d);
        end
    endtask

    task automatic wait_busy();
        bit hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge clk);
            if (bus.o_busy) hit = 1'b1;
        end
        if (!hit) begin
            checks++; errors++;
            $display("FAIL wait_busy timeout actual busy=0 required busy=1");
        end
    endtask

    task automatic wait_drain(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0) done = 1'b1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s drain actual pending=%0d required pending=0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        reset       = 1'b1;
        bus.i_value = '0;
        bus.i_load  = 1'b0;
        checks      = 0;
        errors      = 0;
        seg_idx     = 0;
        armed       = 1'b0;
        cur_key     = '0;
        cur_len     = 0;

        // Segment monitor: a segment closes when the observed output tuple changes.
        fork
            forever begin
                logic [12:0] k;
                @(negedge clk);
                if (reset) begin
                    armed = 1'b0;
                end else begin
                    k = {bus.o_busy, bus.fnd_digit, bus.fnd_data};
                    if (!armed) begin
                        if (bus.fnd_digit != 4'b1111) begin
                            armed   = 1'b1;
                            cur_key = k;
                            cur_len = 1;
                        end
                    end else if (k == cur_key) begin
                        cur_len++;
                    end else begin
                        close_seg();
                        cur_key = k;
                        cur_len = 1;
                    end
                end
            end
        join_none

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_reset_outs("reset_init");
        end

        // Two idle frames of zero after release
        push_frame(8'hC0, LZ, LZ, LZ);
        push_frame(8'hC0, LZ, LZ, LZ);
        @(posedge clk);
        #1 reset = 1'b0;
        wait_drain("idle");

        // 1234 loaded mid-frame
        push_frame(8'hC0, LZ, LZ, LZ);
        push_busy();
        push_frame(8'h99, 8'hB0, 8'hA4, 8'hF9);
        wait_dig(4'b1101);
        load(14'd1234);
        wait_drain("v1234");

        // 10000 saturates to 9999
        push_frame(8'h99, 8'hB0, 8'hA4, 8'hF9);
        push_busy();
        push_frame(8'h90, 8'h90, 8'h90, 8'h90);
        wait_dig(4'b1101);
        load(14'd10000);
        wait_drain("v10000");

        // Three loads in one frame: last wins, single conversion
        push_frame(8'h90, 8'h90, 8'h90, 8'h90);
        push_busy();
        push_frame(8'hB0, 8'hB0, LZ, LZ);
        wait_dig(4'b1110);
        load(14'd11);
        wait_dig(4'b1101);
        load(14'd22);
        wait_dig(4'b1011);
        load(14'd33);
        wait_drain("multi_load");

        // 16383 saturates to 9999
        push_frame(8'hB0, 8'hB0, LZ, LZ);
        push_busy();
        push_frame(8'h90, 8'h90, 8'h90, 8'h90);
        wait_dig(4'b1101);
        load(14'd16383);
        wait_drain("v16383");

        // Boundary-cycle load bypasses shadow; load during conversion queues next frame
        push_frame(8'h90, 8'h90, 8'h90, 8'h90);
        push_busy();
        push_frame(8'hF8, 8'hF8, LZ, LZ);
        push_busy();
        push_frame(8'h80, 8'h80, LZ, LZ);
        wait_dig(4'b0111);
        wait_dig(4'b1111);
        load(14'd77);
        wait_busy();
        load(14'd88);
        wait_drain("boundary_load");

        // Reset in the middle of converting 5678
        push_frame(8'h80, 8'h80, LZ, LZ);
        wait_dig(4'b1101);
        load(14'd5678);
        wait_busy();
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pre_reset_queue actual pending=%0d required pending=0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_reset_outs("reset_conv");
        end
        push_frame(8'hC0, LZ, LZ, LZ);
        @(posedge clk);
        #1 reset = 1'b0;
        wait_drain("post_reset");

        // 42 exercises leading-zero handling on two upper digits
        push_frame(8'hC0, LZ, LZ, LZ);
        push_busy();
        push_frame(8'hA4, 8'h99, LZ, LZ);
        wait_dig(4'b1101);
        load(14'd42);
        wait_drain("v42");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
